// File: rtl/fp_datapath.sv
// Register file plus integer ALU datapath for the FP square-root unit; 8 entries, 2 read / 1 write.
// Latency: reads, ALU, flags and data_o are combinational; register writes land on the rising clk edge.
// Backpressure: none; the external controller drives every control input every cycle.
module fp_datapath #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  IE,
    input  logic                  WE,
    input  logic                  OE,
    input  logic [ADDR_WIDTH-1:0] ADDR_WR,
    input  logic [ADDR_WIDTH-1:0] ADDR_RDA,
    input  logic [ADDR_WIDTH-1:0] ADDR_RDB,
    input  logic [1:0]            ALU_Op,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  negative_o,
    output logic                  zero_o
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_SHR  = 2'b10,
        OP_PASS = 2'b11
    } alu_op_e;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] opnd_a;
    logic [DATA_WIDTH-1:0] opnd_b;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] wr_data_d;

    // No write bypass: reads always see the pre-edge contents.
    assign opnd_a = regs_q[ADDR_RDA];
    assign opnd_b = regs_q[ADDR_RDB];

    always_comb begin
        alu_result = '0;
        case (alu_op_e'(ALU_Op))
            OP_ADD:  alu_result = opnd_a + opnd_b;
            OP_SUB:  alu_result = opnd_a - opnd_b;
            OP_SHR:  alu_result = {1'b0, opnd_a[DATA_WIDTH-1:1]};
            OP_PASS: alu_result = opnd_a;
            default: alu_result = '0;
        endcase
    end

    assign wr_data_d = IE ? data_i : alu_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (WE) begin
            regs_q[ADDR_WR] <= wr_data_d;
        end
    end

    assign data_o     = OE ? alu_result : '0;
    assign negative_o = alu_result[DATA_WIDTH-1];
    assign zero_o     = (alu_result == '0);

endmodule

// File: tb/tb_fp_datapath.sv
// Bench for fp_datapath: directed scenarios plus randomized traffic against an array-based reference model.
module tb_fp_datapath;

    logic        clk;
    logic        rst_n;
    logic        IE;
    logic        WE;
    logic        OE;
    logic [2:0]  ADDR_WR;
    logic [2:0]  ADDR_RDA;
    logic [2:0]  ADDR_RDB;
    logic [1:0]  ALU_Op;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        negative_o;
    logic        zero_o;

    int tests;
    int fails;
    logic [31:0] model [8];

    fp_datapath #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .IE        (IE),
        .WE        (WE),
        .OE        (OE),
        .ADDR_WR   (ADDR_WR),
        .ADDR_RDA  (ADDR_RDA),
        .ADDR_RDB  (ADDR_RDB),
        .ALU_Op    (ALU_Op),
        .data_i    (data_i),
        .data_o    (data_o),
        .negative_o(negative_o),
        .zero_o    (zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned r;
        case (op)
            2'd0:    r = (longint'(a) + longint'(b)) % 64'h1_0000_0000;
            2'd1:    r = (64'h1_0000_0000 + longint'(a) - longint'(b)) % 64'h1_0000_0000;
            2'd2:    r = longint'(a) / 2;
            default: r = longint'(a);
        endcase
        return r[31:0];
    endfunction

    // One clock edge; the model applies the architectural write rule to the pre-edge state.
    task automatic step();
        logic [31:0] nv;
        logic        wr;
        nv = IE ? data_i : alu_ref(ALU_Op, model[ADDR_RDA], model[ADDR_RDB]);
        wr = rst_n && WE;
        @(posedge clk);
        if (wr) model[ADDR_WR] = nv;
        #1;
    endtask

    task automatic load(input logic [2:0] a, input logic [31:0] v);
        IE = 1'b1; WE = 1'b1; ADDR_WR = a; data_i = v;
        step();
        WE = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) model[i] = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; IE = 0; WE = 0; OE = 1; ADDR_WR = 0; ADDR_RDA = 0; ADDR_RDB = 0; ALU_Op = 2'b11; data_i = 0;
        model_clear();
        #23;
        rst_n = 1'b1;
        #4;
        for (int k = 0; k < 8; k++) begin
            ADDR_RDA = 3'(k); #1;
            tests++;
            if (data_o !== 32'd0) begin fails++; $display("FAIL reset_r%0d: got %h want 0", k, data_o); end
        end
        tests++;
        if (zero_o !== 1'b1 || negative_o !== 1'b0) begin
            fails++; $display("FAIL reset_flags: got z=%b n=%b want z=1 n=0", zero_o, negative_o);
        end
    endtask

    task automatic test_load_all();
        for (int k = 0; k < 8; k++) load(3'(k), 32'd4);
        OE = 1; ALU_Op = 2'b11;
        for (int k = 0; k < 8; k++) begin
            ADDR_RDA = 3'(k); #1;
            tests++;
            if (data_o !== 32'd4 || negative_o !== 1'b0 || zero_o !== 1'b0) begin
                fails++; $display("FAIL load_all_r%0d: got %h n=%b z=%b want 4 n=0 z=0", k, data_o, negative_o, zero_o);
            end
        end
    endtask

    task automatic test_sub_add();
        load(3'd1, 32'd4); load(3'd2, 32'd4);
        OE = 1; ADDR_RDA = 1; ADDR_RDB = 2; ALU_Op = 2'b01; #1;
        tests++;
        if (data_o !== 32'd0 || zero_o !== 1'b1 || negative_o !== 1'b0) begin
            fails++; $display("FAIL sub_eq: got %h z=%b n=%b want 0 z=1 n=0", data_o, zero_o, negative_o);
        end
        ALU_Op = 2'b00; #1;
        tests++;
        if (data_o !== 32'd8 || zero_o !== 1'b0) begin
            fails++; $display("FAIL add_4_4: got %h z=%b want 8 z=0", data_o, zero_o);
        end
    endtask

    task automatic test_writeback();
        load(3'd1, 32'd4);
        IE = 0; WE = 1; ADDR_WR = 3; ADDR_RDA = 1; ADDR_RDB = 1; ALU_Op = 2'b00;
        step();
        WE = 0; OE = 1; ALU_Op = 2'b11; ADDR_RDA = 3; #1;
        tests++;
        if (data_o !== 32'd8) begin fails++; $display("FAIL wb_add: got %h want 8", data_o); end
        IE = 0; WE = 1; ADDR_WR = 4; ADDR_RDA = 3; ALU_Op = 2'b10;
        step();
        WE = 0; ALU_Op = 2'b11; ADDR_RDA = 4; #1;
        tests++;
        if (data_o !== 32'd4) begin fails++; $display("FAIL wb_shr: got %h want 4", data_o); end
        // Self-referencing write: r1 <= r1 + r1 uses the pre-edge value.
        IE = 0; WE = 1; ADDR_WR = 1; ADDR_RDA = 1; ADDR_RDB = 1; ALU_Op = 2'b00;
        step();
        WE = 0; ALU_Op = 2'b11; ADDR_RDA = 1; #1;
        tests++;
        if (data_o !== 32'd8) begin fails++; $display("FAIL wb_double: got %h want 8", data_o); end
    endtask

    task automatic test_wrap();
        load(3'd1, 32'd0); load(3'd2, 32'd4);
        OE = 1; ADDR_RDA = 1; ADDR_RDB = 2; ALU_Op = 2'b01; #1;
        tests++;
        if (data_o !== 32'hFFFF_FFFC || negative_o !== 1'b1 || zero_o !== 1'b0) begin
            fails++; $display("FAIL sub_neg: got %h n=%b z=%b want fffffffc n=1 z=0", data_o, negative_o, zero_o);
        end
        load(3'd1, 32'hFFFF_FFFF); load(3'd2, 32'd1);
        ADDR_RDA = 1; ADDR_RDB = 2; ALU_Op = 2'b00; #1;
        tests++;
        if (data_o !== 32'd0 || zero_o !== 1'b1 || negative_o !== 1'b0) begin
            fails++; $display("FAIL add_wrap: got %h z=%b n=%b want 0 z=1 n=0", data_o, zero_o, negative_o);
        end
        ALU_Op = 2'b10; ADDR_RDA = 1; #1;
        tests++;
        if (data_o !== 32'h7FFF_FFFF || negative_o !== 1'b0) begin
            fails++; $display("FAIL shr_msb: got %h n=%b want 7fffffff n=0", data_o, negative_o);
        end
    endtask

    task automatic test_oe_we();
        load(3'd1, 32'd4); load(3'd2, 32'd4);
        OE = 0; ADDR_RDA = 1; ADDR_RDB = 2; ALU_Op = 2'b01; #1;
        tests++;
        if (data_o !== 32'd0 || zero_o !== 1'b1) begin
            fails++; $display("FAIL oe_off_sub: got %h z=%b want 0 z=1", data_o, zero_o);
        end
        ALU_Op = 2'b00; #1;
        tests++;
        if (data_o !== 32'd0 || zero_o !== 1'b0) begin
            fails++; $display("FAIL oe_off_add: got %h z=%b want 0 z=0", data_o, zero_o);
        end
        IE = 1; WE = 0; data_i = 32'd9;
        for (int k = 0; k < 8; k++) begin ADDR_WR = 3'(k); step(); end
        OE = 1; ALU_Op = 2'b11;
        for (int k = 0; k < 8; k++) begin
            ADDR_RDA = 3'(k); #1;
            tests++;
            if (data_o !== model[k]) begin fails++; $display("FAIL we_off_r%0d: got %h want %h", k, data_o, model[k]); end
        end
    endtask

    task automatic test_midrun_reset();
        for (int k = 0; k < 8; k++) load(3'(k), 32'h100 + 32'(k));
        OE = 1; ALU_Op = 2'b11;
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        for (int k = 0; k < 8; k++) begin
            ADDR_RDA = 3'(k); #0.1;
            tests++;
            if (data_o !== 32'd0) begin fails++; $display("FAIL midreset_r%0d: got %h want 0", k, data_o); end
        end
        IE = 1; WE = 1; ADDR_WR = 5; data_i = 32'h55;
        step();
        WE = 0; ADDR_RDA = 5; #1;
        tests++;
        if (data_o !== 32'd0) begin fails++; $display("FAIL write_in_reset: got %h want 0", data_o); end
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_random();
        logic [31:0] exp_r;
        for (int n = 0; n < 300; n++) begin
            IE = 1'($urandom); WE = 1'($urandom); OE = 1'($urandom);
            ADDR_WR = 3'($urandom); ADDR_RDA = 3'($urandom); ADDR_RDB = 3'($urandom);
            ALU_Op = 2'($urandom);
            case ($urandom_range(0, 3))
                0: data_i = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                1: data_i = 32'($urandom_range(0, 3));
                default: data_i = $urandom;
            endcase
            #1;
            exp_r = alu_ref(ALU_Op, model[ADDR_RDA], model[ADDR_RDB]);
            tests++;
            if (data_o !== (OE ? exp_r : 32'd0) || negative_o !== exp_r[31] || zero_o !== (exp_r == 32'd0)) begin
                fails++;
                $display("FAIL rand_%0d: got %h n=%b z=%b want %h n=%b z=%b", n, data_o, negative_o, zero_o,
                         OE ? exp_r : 32'd0, exp_r[31], exp_r == 32'd0);
            end
            step();
        end
        WE = 0; OE = 1; ALU_Op = 2'b11;
        for (int k = 0; k < 8; k++) begin
            ADDR_RDA = 3'(k); #1;
            tests++;
            if (data_o !== model[k]) begin fails++; $display("FAIL rand_final_r%0d: got %h want %h", k, data_o, model[k]); end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_load_all();
        test_sub_add();
        test_writeback();
        test_wrap();
        test_oe_we();
        test_midrun_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
